// File: rtl/analog_ramp_pkg.sv
// Shared types and helpers for the analog ramp controller.
// The direction enum tracks what a channel did on its previous frame.
package analog_ramp_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    function automatic int clamp_val(input int v, input int lo, input int hi);
        int r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/analog_ramp_ctrl_if.sv
// Button/joystick inputs and control-value outputs of the ramp controller.
// The master side is the input decoder; the slave side is the controller.
interface analog_ramp_ctrl_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8
) ();
    logic                   vsync;
    logic [NCH-1:0]         plus;
    logic [NCH-1:0]         minus;
    logic [NCH-1:0]         center_mode;
    logic [NCH*8-1:0]       analog_in;
    logic [NCH-1:0]         analog_valid;
    logic [NCH*WIDTH-1:0]   value;
    logic                   frame_tick;

    modport master (
        output vsync, plus, minus, center_mode, analog_in, analog_valid,
        input  value, frame_tick
    );

    modport slave (
        input  vsync, plus, minus, center_mode, analog_in, analog_valid,
        output value, frame_tick
    );
endinterface

// File: rtl/analog_ramp_chan.sv
// One control channel: ramps on buttons, accelerates on long holds,
// self-centres or holds on release, and follows the joystick when valid.
module analog_ramp_chan
    import analog_ramp_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CENTER       = 128,
    parameter int VMIN         = 0,
    parameter int VMAX         = 255,
    parameter int STEP         = 4,
    parameter int RETURN_STEP  = 8,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             plus,
    input  logic             minus,
    input  logic             center_mode,
    input  logic             analog_valid,
    input  logic [7:0]       analog_in,
    output logic [WIDTH-1:0] value
);
    localparam int CW = $clog2(ACCEL_FRAMES + 1);
    localparam logic [CW-1:0]          ACCEL_C  = CW'(ACCEL_FRAMES);
    localparam logic [CW-1:0]          ONE_C    = CW'(1);
    localparam logic signed [WIDTH+1:0] CENTER_W = (WIDTH+2)'(CENTER);
    localparam logic signed [WIDTH+1:0] STEP_W   = (WIDTH+2)'(STEP);
    localparam logic signed [WIDTH+1:0] STEP2_W  = (WIDTH+2)'(2 * STEP);
    localparam logic signed [WIDTH+1:0] RET_W    = (WIDTH+2)'(RETURN_STEP);

    logic [WIDTH-1:0]          value_r, value_n_s;
    dir_t                      dir_r, dir_n_s, want_s;
    logic [CW-1:0]             cnt_r, cnt_n_s, cnt_eff_s;
    logic signed [WIDTH+1:0]   cur_s, step_s, diff_s, sum_s;

    assign cur_s = signed'({2'b00, value_r});
    assign value = value_r;

    // Channel state register; reset returns to rest value with no hold history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= WIDTH'(CENTER);
            dir_r   <= DIR_NONE;
            cnt_r   <= '0;
        end else begin
            value_r <= value_n_s;
            dir_r   <= dir_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Next-state: priority analog > single button > release behaviour.
    always_comb begin
        value_n_s = value_r;
        dir_n_s   = dir_r;
        cnt_n_s   = cnt_r;
        sum_s     = cur_s;
        if (plus && !minus) begin
            want_s = DIR_UP;
        end else if (minus && !plus) begin
            want_s = DIR_DN;
        end else begin
            want_s = DIR_NONE;
        end
        // A reversal restarts the hold count, so the first reversed step is never doubled.
        cnt_eff_s = (want_s == dir_r) ? cnt_r : '0;
        step_s    = (cnt_eff_s < ACCEL_C) ? STEP_W : STEP2_W;
        diff_s    = cur_s - CENTER_W;
        if (!tick) begin
            sum_s = cur_s;
        end else if (analog_valid) begin
            sum_s   = CENTER_W + ({{(WIDTH-6){analog_in[7]}}, analog_in} << (WIDTH-8));
            cnt_n_s = '0;
            dir_n_s = DIR_NONE;
        end else if (want_s != DIR_NONE) begin
            sum_s   = (want_s == DIR_UP) ? (cur_s + step_s) : (cur_s - step_s);
            cnt_n_s = (cnt_eff_s == ACCEL_C) ? ACCEL_C : (cnt_eff_s + ONE_C);
            dir_n_s = want_s;
        end else begin
            cnt_n_s = '0;
            dir_n_s = DIR_NONE;
            if (!center_mode) begin
                sum_s = cur_s;
            end else if (diff_s > RET_W) begin
                sum_s = cur_s - RET_W;
            end else if (diff_s < -RET_W) begin
                sum_s = cur_s + RET_W;
            end else begin
                sum_s = CENTER_W;
            end
        end
        if (tick) begin
            value_n_s = WIDTH'(clamp_val(int'(sum_s), VMIN, VMAX));
        end else begin
            value_n_s = value_r;
        end
    end
endmodule

// File: rtl/analog_ramp_ctrl.sv
// Multi-channel analog control emulator: synchronises vsync into a frame
// tick and drives NCH independent ramp channels from it.
module analog_ramp_ctrl
    import analog_ramp_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int WIDTH        = 8,
    parameter int CENTER       = 128,
    parameter int VMIN         = 0,
    parameter int VMAX         = 255,
    parameter int STEP         = 4,
    parameter int RETURN_STEP  = 8,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    analog_ramp_ctrl_if.slave  bus
);
    logic                 vsync_meta_r, vsync_sync_r, vsync_prev_r, frame_tick_r;
    logic [NCH*WIDTH-1:0] value_s;

    // vsync synchroniser and rising-edge detector; the tick is registered.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vsync_meta_r <= 1'b0;
            vsync_sync_r <= 1'b0;
            vsync_prev_r <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            vsync_meta_r <= bus.vsync;
            vsync_sync_r <= vsync_meta_r;
            vsync_prev_r <= vsync_sync_r;
            frame_tick_r <= vsync_sync_r & ~vsync_prev_r;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        analog_ramp_chan #(
            .WIDTH        (WIDTH),
            .CENTER       (CENTER),
            .VMIN         (VMIN),
            .VMAX         (VMAX),
            .STEP         (STEP),
            .RETURN_STEP  (RETURN_STEP),
            .ACCEL_FRAMES (ACCEL_FRAMES)
        ) u_chan (
            .clk          (clk_sys),
            .rst          (reset),
            .tick         (frame_tick_r),
            .plus         (bus.plus[g]),
            .minus        (bus.minus[g]),
            .center_mode  (bus.center_mode[g]),
            .analog_valid (bus.analog_valid[g]),
            .analog_in    (bus.analog_in[g*8 +: 8]),
            .value        (value_s[g*WIDTH +: WIDTH])
        );
    end

    assign bus.value      = value_s;
    assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_analog_ramp_ctrl.sv
// Directed plus randomized bench for analog_ramp_ctrl against a frame-level
// arithmetic model of the channel rules.
module tb_analog_ramp_ctrl;
    localparam int NCH    = 2;
    localparam int WIDTH  = 8;
    localparam int CENTER = 128;
    localparam int VMIN   = 0;
    localparam int VMAX   = 255;
    localparam int STEP   = 4;
    localparam int RSTEP  = 8;
    localparam int ACCEL  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    analog_ramp_ctrl_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

    analog_ramp_ctrl #(
        .NCH(NCH), .WIDTH(WIDTH), .CENTER(CENTER), .VMIN(VMIN), .VMAX(VMAX),
        .STEP(STEP), .RETURN_STEP(RSTEP), .ACCEL_FRAMES(ACCEL)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int mval[NCH];
    int mrun[NCH];
    int mdir[NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] chval(input int c);
        return 32'(bus.value[c*WIDTH +: WIDTH]);
    endfunction

    function automatic int lim(input int v);
        return (v < VMIN) ? VMIN : ((v > VMAX) ? VMAX : v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mval[c] = CENTER;
            mrun[c] = 0;
            mdir[c] = 0;
        end
    endtask

    // One frame of the channel rules, expressed on plain integers.
    task automatic model_frame();
        for (int c = 0; c < NCH; c++) begin
            int d;
            int s;
            if (bus.analog_valid[c]) begin
                s = int'(bus.analog_in[c*8 +: 8]);
                if (s > 127) s -= 256;
                mval[c] = lim(CENTER + s * (1 << (WIDTH - 8)));
                mrun[c] = 0;
                mdir[c] = 0;
            end else if (bus.plus[c] != bus.minus[c]) begin
                d = bus.plus[c] ? 1 : -1;
                if (d != mdir[c]) mrun[c] = 0;
                mval[c] = lim(mval[c] + d * ((mrun[c] >= ACCEL) ? 2 * STEP : STEP));
                mrun[c] = (mrun[c] < ACCEL) ? mrun[c] + 1 : ACCEL;
                mdir[c] = d;
            end else begin
                if (bus.center_mode[c]) begin
                    if (mval[c] > CENTER + RSTEP) mval[c] -= RSTEP;
                    else if (mval[c] < CENTER - RSTEP) mval[c] += RSTEP;
                    else mval[c] = CENTER;
                end
                mrun[c] = 0;
                mdir[c] = 0;
            end
        end
    endtask

    task automatic frame();
        @(negedge clk);
        bus.vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("tick_early", 32'(bus.frame_tick), 32'd0);
        @(negedge clk);
        chk("tick_high", 32'(bus.frame_tick), 32'd1);
        model_frame();
        @(negedge clk);
        chk("tick_width", 32'(bus.frame_tick), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("model_val%0d", c), chval(c), 32'(mval[c]));
        end
        bus.vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.vsync        = 1'b0;
        bus.plus         = '0;
        bus.minus        = '0;
        bus.center_mode  = '0;
        bus.analog_in    = '0;
        bus.analog_valid = '0;
        reset            = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_val0", chval(0), 32'd128);
        chk("rst_val1", chval(1), 32'd128);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);
        reset = 1'b0;

        repeat (3) frame();
        chk("idle_val0", chval(0), 32'd128);

        bus.plus[0] = 1'b1;
        repeat (16) frame();
        chk("ramp16", chval(0), 32'd192);
        frame();
        chk("accel_step", chval(0), 32'd200);
        repeat (23) frame();
        chk("saturate", chval(0), 32'd255);
        chk("ch1_idle", chval(1), 32'd128);
        bus.plus[0] = 1'b0;

        bus.analog_valid[0] = 1'b1;
        bus.analog_in[7:0]  = 8'd72;
        frame();
        chk("analog_200", chval(0), 32'd200);
        bus.analog_valid[0] = 1'b0;
        bus.center_mode[0]  = 1'b1;
        frame();
        chk("centre_192", chval(0), 32'd192);
        repeat (8) frame();
        chk("centre_128", chval(0), 32'd128);
        frame();
        chk("centre_stay", chval(0), 32'd128);
        bus.analog_valid[0] = 1'b1;
        bus.analog_in[7:0]  = 8'd3;
        frame();
        chk("analog_131", chval(0), 32'd131);
        bus.analog_valid[0] = 1'b0;
        frame();
        chk("no_overshoot", chval(0), 32'd128);

        bus.analog_valid[1] = 1'b1;
        bus.analog_in[15:8] = 8'd22;
        frame();
        bus.analog_valid[1] = 1'b0;
        bus.center_mode[1]  = 1'b0;
        frame();
        chk("hold_150", chval(1), 32'd150);
        bus.plus[1] = 1'b1;
        repeat (20) frame();
        chk("hold_ramp", chval(1), 32'd246);
        bus.plus[1]  = 1'b0;
        bus.minus[1] = 1'b1;
        frame();
        chk("reversal", chval(1), 32'd242);
        bus.minus[1] = 1'b0;

        bus.analog_valid[0] = 1'b1;
        bus.analog_in[7:0]  = 8'h80;
        frame();
        chk("analog_min", chval(0), 32'd0);
        bus.analog_in[7:0] = 8'h7F;
        frame();
        chk("analog_max", chval(0), 32'd255);
        bus.analog_valid[0] = 1'b0;
        bus.center_mode     = '0;
        bus.plus            = '1;
        bus.minus           = '1;
        frame();
        chk("both_hold0", chval(0), 32'd255);
        chk("both_hold1", chval(1), 32'd242);

        for (int i = 0; i < 14; i++) begin
            bus.plus        = NCH'($urandom);
            bus.minus       = NCH'($urandom);
            bus.center_mode = NCH'($urandom);
            bus.analog_in   = (NCH*8)'($urandom);
            for (int c = 0; c < NCH; c++) begin
                bus.analog_valid[c] = ($urandom_range(0, 4) == 0);
            end
            repeat ($urandom_range(1, 20)) frame();
        end

        bus.analog_valid = '0;
        bus.minus        = '0;
        bus.plus         = '1;
        repeat (5) frame();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_val0", chval(0), 32'd128);
        chk("midrst_val1", chval(1), 32'd128);
        chk("midrst_tick", 32'(bus.frame_tick), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        frame();
        chk("post_rst", chval(0), 32'd132);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
